// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM interface controller.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWSetup,
    StWPulse,
    StWHold,
    StRAccess,
    StTurn
  } state_e;

  localparam int unsigned DefSetupCyc = 1;
  localparam int unsigned DefPulseCyc = 2;
  localparam int unsigned DefHoldCyc  = 1;
  localparam int unsigned DefReadCyc  = 2;

  function automatic int unsigned max_phase(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Bits needed to hold values 0..max_cyc, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_cyc);
    return (max_cyc == 0) ? 1 : $clog2(max_cyc + 1);
  endfunction

endpackage

// File: rtl/sram_phase_cnt.sv
// Loadable down-counter; done is high while the count sits at zero.
module sram_phase_cnt #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             done
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/sram_if_ctrl.sv
// Request/response sequencer producing registered CE/WE/OE strobes for an async SRAM.
module sram_if_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned AW        = 7,
  parameter int unsigned DW        = 8,
  parameter int unsigned SETUP_CYC = DefSetupCyc,
  parameter int unsigned PULSE_CYC = DefPulseCyc,
  parameter int unsigned HOLD_CYC  = DefHoldCyc,
  parameter int unsigned READ_CYC  = DefReadCyc
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_dout,
  output logic          sram_dout_en,
  input  logic [DW-1:0] sram_din,
  output logic          sram_ce_n,
  output logic          sram_we_n,
  output logic          sram_oe_n
);

  localparam int unsigned CW = cnt_width(max_phase(SETUP_CYC, PULSE_CYC, HOLD_CYC, READ_CYC));

  if (SETUP_CYC < 1) begin : g_bad_setup
    $error("SETUP_CYC must be at least 1");
  end
  if (PULSE_CYC < 1) begin : g_bad_pulse
    $error("PULSE_CYC must be at least 1");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("HOLD_CYC must be at least 1");
  end
  if (READ_CYC < 1) begin : g_bad_read
    $error("READ_CYC must be at least 1");
  end

  state_e          state_q, state_d;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q, rdata_q;
  logic            cnt_load, cnt_done;
  logic [CW-1:0]   cnt_load_val;
  logic            ce_n_q, we_n_q, oe_n_q, dout_en_q, rsp_valid_q, ready_q;
  logic            ce_n_d, we_n_d, oe_n_d, dout_en_d, rsp_valid_d, ready_d;
  logic            accept;

  assign accept = req_valid && ready_q;

  sram_phase_cnt #(
    .Width(CW)
  ) u_phase_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .done    (cnt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_load = 1'b1;
          if (req_we) begin
            state_d      = StWSetup;
            cnt_load_val = CW'(SETUP_CYC - 1);
          end else begin
            state_d      = StRAccess;
            cnt_load_val = CW'(READ_CYC - 1);
          end
        end
      end
      StWSetup: begin
        if (cnt_done) begin
          state_d      = StWPulse;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(PULSE_CYC - 1);
        end
      end
      StWPulse: begin
        if (cnt_done) begin
          state_d      = StWHold;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(HOLD_CYC - 1);
        end
      end
      StWHold:   if (cnt_done) state_d = StTurn;
      StRAccess: if (cnt_done) state_d = StTurn;
      StTurn:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state so every output leaves a flop.
  always_comb begin
    ce_n_d      = !(state_d inside {StWSetup, StWPulse, StWHold, StRAccess});
    we_n_d      = (state_d != StWPulse);
    oe_n_d      = (state_d != StRAccess);
    dout_en_d   = (state_d inside {StWSetup, StWPulse, StWHold});
    rsp_valid_d = (state_d == StTurn) && !we_q;
    ready_d     = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      dout_en_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      dout_en_q   <= dout_en_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == StRAccess && cnt_done) begin
        rdata_q <= sram_din;
      end
    end
  end

  assign req_ready    = ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign sram_a       = addr_q;
  assign sram_dout    = wdata_q;
  assign sram_dout_en = dout_en_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_we_n    = we_n_q;
  assign sram_oe_n    = oe_n_q;

endmodule

// File: tb/tb_sram_if_ctrl.sv
// Bench for sram_if_ctrl: default and stretched-timing instances sharing one SRAM model.
module tb_sram_if_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       req_valid, req_we;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;

  logic [1:0] rdy_w, rspv_w, ce_w, we_w, oe_w, den_w, valid_w;
  logic [6:0] a_w    [2];
  logic [7:0] dout_w [2];
  logic [7:0] rdata_w[2];

  logic       req_ready, rsp_valid, sram_ce_n, sram_we_n, sram_oe_n, sram_dout_en;
  logic [6:0] sram_a;
  logic [7:0] sram_dout, rsp_rdata, sram_din;

  logic [7:0] mem     [128];
  logic [7:0] ref_mem [128];
  logic       ref_ok  [128];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int s_cyc, p_cyc, h_cyc, r_cyc;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign valid_w      = {sel & req_valid, ~sel & req_valid};
  assign req_ready    = rdy_w[sel];
  assign rsp_valid    = rspv_w[sel];
  assign sram_ce_n    = ce_w[sel];
  assign sram_we_n    = we_w[sel];
  assign sram_oe_n    = oe_w[sel];
  assign sram_dout_en = den_w[sel];
  assign sram_a       = a_w[sel];
  assign sram_dout    = dout_w[sel];
  assign rsp_rdata    = rdata_w[sel];
  assign sram_din     = (!sram_ce_n && !sram_oe_n) ? mem[sram_a] : 8'h5A;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dout_en) mem[sram_a] <= sram_dout;
  end

  sram_if_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_w[0]), .req_ready(rdy_w[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspv_w[0]), .rsp_rdata(rdata_w[0]), .sram_a(a_w[0]), .sram_dout(dout_w[0]),
    .sram_dout_en(den_w[0]), .sram_din(sram_din), .sram_ce_n(ce_w[0]), .sram_we_n(we_w[0]),
    .sram_oe_n(oe_w[0])
  );

  sram_if_ctrl #(
    .AW(7), .DW(8), .SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2), .READ_CYC(5)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_w[1]), .req_ready(rdy_w[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspv_w[1]), .rsp_rdata(rdata_w[1]), .sram_a(a_w[1]), .sram_dout(dout_w[1]),
    .sram_dout_en(den_w[1]), .sram_din(sram_din), .sram_ce_n(ce_w[1]), .sram_we_n(we_w[1]),
    .sram_oe_n(oe_w[1])
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Protocol rules evaluated every cycle while enabled.
  logic       pv_we_low, pv_rsp;
  logic [6:0] pv_a;
  logic [7:0] pv_dout;
  always @(negedge clk) begin
    logic bad;
    if (rst_n && chk_on) begin
      bad = (!sram_we_n && pv_we_low && (sram_a != pv_a || sram_dout != pv_dout))
          || (sram_dout_en && !sram_oe_n)
          || (rsp_valid && pv_rsp)
          || (req_ready && (!sram_ce_n || !sram_we_n || !sram_oe_n || sram_dout_en || rsp_valid));
      check("protocol", int'(bad), 0);
    end
    pv_we_low <= rst_n && !sram_we_n;
    pv_rsp    <= rst_n && rsp_valid;
    pv_a      <= sram_a;
    pv_dout   <= sram_dout;
  end

  task automatic wait_ready();
    for (int n = 0; n < 64 && !req_ready; n++) @(negedge clk);
    check("ready_timeout", int'(req_ready), 1);
  endtask

  // One access; checks strobe timing against the phase parameters, returns read data.
  task automatic xfer(input logic we, input logic [6:0] addr, input logic [7:0] wdata,
                      output logic [7:0] rdata);
    int ce_low = 0, we_low = 0, we_first = 0, rsp_at = 0, busy = 0;
    logic done = 1'b0;
    logic a_ok = 1'b1;
    rdata = 8'h00;
    wait_ready();
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 7'($urandom); req_wdata = 8'($urandom); req_we = 1'($urandom);
    for (int c = 1; c <= 64 && !done; c++) begin
      if (!sram_ce_n) ce_low++;
      if (!sram_we_n) begin
        we_low++;
        if (we_first == 0) we_first = c;
      end
      if (rsp_valid && rsp_at == 0) begin
        rsp_at = c;
        rdata  = rsp_rdata;
      end
      if (!sram_ce_n && (sram_a != addr || (we && sram_dout != wdata))) a_ok = 1'b0;
      if (req_ready) begin
        busy = c - 1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check("xfer_done", int'(done), 1);
    check("addr_data_stable", int'(a_ok), 1);
    if (we) begin
      check("w_ce_low_len", ce_low, s_cyc + p_cyc + h_cyc);
      check("w_we_low_len", we_low, p_cyc);
      check("w_we_fall_at", we_first, s_cyc + 1);
      check("w_busy", busy, s_cyc + p_cyc + h_cyc + 1);
    end else begin
      check("r_ce_low_len", ce_low, r_cyc);
      check("r_we_low_len", we_low, 0);
      check("r_latency", rsp_at, r_cyc + 1);
      check("r_busy", busy, r_cyc + 1);
    end
  endtask

  typedef struct {
    logic       we;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t       tbl[9];
    logic [7:0] rd;
    int         t1, t2;

    tbl[0] = '{1'b1, 7'h7F, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 7'h7F, 8'h00, 8'h00};
    tbl[2] = '{1'b1, 7'h01, 8'h3C, 8'h00};
    tbl[3] = '{1'b1, 7'h02, 8'hC3, 8'h00};
    tbl[4] = '{1'b0, 7'h01, 8'h00, 8'h3C};
    tbl[5] = '{1'b0, 7'h02, 8'h00, 8'hC3};
    tbl[6] = '{1'b1, 7'h00, 8'hAA, 8'h00};
    tbl[7] = '{1'b0, 7'h00, 8'h00, 8'hAA};
    tbl[8] = '{1'b0, 7'h7F, 8'h00, 8'h00};
    for (int i = 0; i < 128; i++) ref_ok[i] = 1'b0;

    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    s_cyc = 1; p_cyc = 2; h_cyc = 1; r_cyc = 2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      check("rst_ce_n", int'(sram_ce_n), 1);
      check("rst_we_n", int'(sram_we_n), 1);
      check("rst_oe_n", int'(sram_oe_n), 1);
      check("rst_dout_en", int'(sram_dout_en), 0);
      check("rst_sram_a", int'(sram_a), 0);
      check("rst_sram_dout", int'(sram_dout), 0);
      check("rst_rsp_valid", int'(rsp_valid), 0);
      check("rst_rsp_rdata", int'(rsp_rdata), 0);
      check("rst_req_ready", int'(req_ready), 1);
    end
    sel = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;

    for (int i = 0; i < 9; i++) begin
      xfer(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd);
      if (tbl[i].we) begin
        ref_mem[tbl[i].addr] = tbl[i].wdata;
        ref_ok[tbl[i].addr]  = 1'b1;
      end else begin
        check($sformatf("tbl%0d_rdata", i), int'(rd), int'(tbl[i].exp));
      end
    end

    // Reset during the second WE-low cycle of a write.
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h7E; req_wdata = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 0; n < 10 && sram_we_n; n++) @(negedge clk);
    @(negedge clk);
    check("pre_rst_we_low", int'(sram_we_n), 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we_n", int'(sram_we_n), 1);
    check("mid_rst_ce_n", int'(sram_ce_n), 1);
    check("mid_rst_dout_en", int'(sram_dout_en), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", int'(req_ready), 1);

    // Back-to-back writes with req_valid held.
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h7E; req_wdata = 8'hFF;
    t1 = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    req_addr = 7'h7D;
    t2 = 0;
    for (int n = 0; n < 20 && t2 == 0; n++) begin
      if (req_ready) t2 = cyc + 1;
      else @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_accept_gap", t2 - t1, s_cyc + p_cyc + h_cyc + 2);
    ref_mem[7'h7E] = 8'hFF; ref_ok[7'h7E] = 1'b1;
    ref_mem[7'h7D] = 8'hFF; ref_ok[7'h7D] = 1'b1;
    xfer(1'b0, 7'h7E, 8'h00, rd);
    check("b2b_rd_7e", int'(rd), 8'hFF);
    xfer(1'b0, 7'h7D, 8'h00, rd);
    check("b2b_rd_7d", int'(rd), 8'hFF);

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 150; i++) begin
      logic       w;
      logic [6:0] a;
      logic [7:0] d;
      w = 1'($urandom);
      a = 7'($urandom);
      d = 8'($urandom);
      if (!ref_ok[a]) w = 1'b1;
      xfer(w, a, d, rd);
      if (w) begin
        ref_mem[a] = d;
        ref_ok[a]  = 1'b1;
      end else begin
        check("rand_rdata", int'(rd), int'(ref_mem[a]));
      end
    end

    // Stretched-timing instance: full address sweep.
    wait_ready();
    sel = 1'b1;
    s_cyc = 3; p_cyc = 4; h_cyc = 2; r_cyc = 5;
    @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      logic [7:0] d;
      d = 8'(i * 29 + 7) ^ 8'hC3;
      xfer(1'b1, 7'(i), d, rd);
      ref_mem[i] = d;
    end
    for (int i = 0; i < 128; i++) begin
      xfer(1'b0, 7'(i), 8'h00, rd);
      check("sweep_rdata", int'(rd), int'(ref_mem[i]));
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
